// File: rtl/abs_cmd_seq_pkg.sv
// Shared definitions for the abstract-command sequencer: cmderr codes, command
// field positions, legal regno windows, FSM states and command decode/validation.
package abs_cmd_seq_pkg;

   localparam logic [2:0] CMDERR_NONE       = 3'd0;
   localparam logic [2:0] CMDERR_BUSY       = 3'd1;
   localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
   localparam logic [2:0] CMDERR_EXCEPT     = 3'd3;
   localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

   localparam int CMD_TYPE_LSB = 24;
   localparam int AARSIZE_LSB  = 20;
   localparam int POSTINC_BIT  = 19;
   localparam int POSTEXEC_BIT = 18;
   localparam int TRANSFER_BIT = 17;
   localparam int WRITE_BIT    = 16;

   localparam logic [2:0]  AARSIZE_32 = 3'd2;
   localparam logic [15:0] REGNO_CSR_HI = 16'h0FFF;
   localparam logic [15:0] REGNO_GPR_LO = 16'h1000;
   localparam logic [15:0] REGNO_GPR_HI = 16'h101F;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_WRITE = 3'd2,
      ST_READ  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // Access Register command with the reserved bit 23 dropped
   typedef struct packed {
      logic [7:0]  cmdtype;
      logic [2:0]  aarsize;
      logic        postinc;
      logic        postexec;
      logic        transfer;
      logic        write;
      logic [15:0] regno;
   } cmd_t;

   function automatic cmd_t decode_cmd(input logic [31:0] w);
      cmd_t c;
      c.cmdtype  = w[CMD_TYPE_LSB +: 8];
      c.aarsize  = w[AARSIZE_LSB +: 3];
      c.postinc  = w[POSTINC_BIT];
      c.postexec = w[POSTEXEC_BIT];
      c.transfer = w[TRANSFER_BIT];
      c.write    = w[WRITE_BIT];
      c.regno    = w[15:0];
      return c;
   endfunction

   // Rules are ordered; the first one that fails decides the error code.
   function automatic logic [2:0] check_cmd(input cmd_t c, input logic halted);
      logic regno_ok;
      regno_ok = (c.regno <= REGNO_CSR_HI) ||
                 ((c.regno >= REGNO_GPR_LO) && (c.regno <= REGNO_GPR_HI));
      if (c.cmdtype != 8'h00)          return CMDERR_NOTSUP;
      if (c.aarsize != AARSIZE_32)     return CMDERR_NOTSUP;
      if (c.postexec)                  return CMDERR_NOTSUP;
      if (!halted)                     return CMDERR_HALTRESUME;
      if (c.transfer && !regno_ok)     return CMDERR_EXCEPT;
      return CMDERR_NONE;
   endfunction

endpackage

// File: rtl/abs_cmd_seq.sv
// Abstract-command sequencer: validates Access Register commands and drives the
// single-port core debug register interface, reporting busy/cmderr to abstractcs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for command write or autoexec trigger
// ST_CHECK | validating latched command against hart state
// ST_WRITE | one-cycle core register write strobe
// ST_READ  | core read outstanding, timeout counter running
// ST_DONE  | optional regno postincrement, then release busy
module abs_cmd_seq
   import abs_cmd_seq_pkg::*;
#(
   parameter int REGNO_W    = 16,
   parameter int TMO_CYCLES = 64
) (
   input  logic               sys_clk,
   input  logic               sys_rst,
   input  logic               cmd_update,
   input  logic [31:0]        command,
   input  logic               autoexec_trig,
   input  logic [31:0]        data0,
   input  logic [2:0]         cmderr_w1c,
   input  logic               hart_halted,
   output logic               busy,
   output logic [2:0]         cmderr,
   output logic               data0_we,
   output logic [31:0]        data0_wdata,
   output logic               regno_upd,
   output logic [REGNO_W-1:0] regno_new,
   output logic               dbg_reg_access,
   output logic               dbg_wr1_rd0,
   output logic [REGNO_W-1:0] dbg_regno,
   output logic [31:0]        dbg_write_data,
   input  logic               dbg_read_data_valid,
   input  logic [31:0]        dbg_read_data
);

   localparam int CNT_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYCLES - 1);

   state_t           state;
   cmd_t             cmd_q;
   logic             cmd_vld;
   logic [CNT_W-1:0] tmo_cnt;

   logic [2:0]  chk_err;
   logic [2:0]  cmderr_nxt;
   logic        trig_any;
   logic        start;
   logic        rd_done;
   logic        tmo_hit;
   logic        enter_done;
   logic [15:0] regno_inc;
   logic        unused_cmd_bit;

   assign unused_cmd_bit = command[23];

   assign trig_any   = cmd_update | autoexec_trig;
   assign start      = (cmd_update | (autoexec_trig & cmd_vld)) & (cmderr == CMDERR_NONE);
   assign chk_err    = check_cmd(cmd_q, hart_halted);
   assign rd_done    = (state == ST_READ) & dbg_read_data_valid;
   assign tmo_hit    = (state == ST_READ) & ~dbg_read_data_valid & (tmo_cnt == TMO_LAST);
   assign regno_inc  = cmd_q.regno + 16'd1;
   assign enter_done = ((state == ST_CHECK) & (chk_err == CMDERR_NONE) & ~cmd_q.transfer) |
                       (state == ST_WRITE) | rd_done;

   // Later assignments take priority: a newly raised error beats the w1c clear.
   always_comb begin
      cmderr_nxt = cmderr & ~cmderr_w1c;
      if (busy && trig_any && (cmderr == CMDERR_NONE))
         cmderr_nxt = CMDERR_BUSY;
      if ((state == ST_CHECK) && (chk_err != CMDERR_NONE))
         cmderr_nxt = chk_err;
      if (tmo_hit)
         cmderr_nxt = CMDERR_EXCEPT;
   end

   assign data0_we    = rd_done;
   assign data0_wdata = rd_done ? dbg_read_data : 32'h0;
   assign dbg_regno   = (state != ST_IDLE) ? REGNO_W'(cmd_q.regno) : '0;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state          <= ST_IDLE;
         cmd_q          <= '0;
         cmd_vld        <= 1'b0;
         tmo_cnt        <= '0;
         busy           <= 1'b0;
         cmderr         <= CMDERR_NONE;
         regno_upd      <= 1'b0;
         regno_new      <= '0;
         dbg_reg_access <= 1'b0;
         dbg_wr1_rd0    <= 1'b0;
         dbg_write_data <= 32'h0;
      end else begin
         cmderr    <= cmderr_nxt;
         regno_upd <= enter_done & cmd_q.postinc;
         if (enter_done && cmd_q.postinc)
            regno_new <= REGNO_W'(regno_inc);

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_CHECK;
                  busy  <= 1'b1;
                  if (cmd_update) begin
                     cmd_q   <= decode_cmd(command);
                     cmd_vld <= 1'b1;
                  end
               end
            end
            ST_CHECK: begin
               if (chk_err != CMDERR_NONE) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (!cmd_q.transfer) begin
                  state <= ST_DONE;
               end else if (cmd_q.write) begin
                  state          <= ST_WRITE;
                  dbg_reg_access <= 1'b1;
                  dbg_wr1_rd0    <= 1'b1;
                  dbg_write_data <= data0;
               end else begin
                  state          <= ST_READ;
                  dbg_reg_access <= 1'b1;
                  dbg_wr1_rd0    <= 1'b0;
                  tmo_cnt        <= '0;
               end
            end
            ST_WRITE: begin
               state          <= ST_DONE;
               dbg_reg_access <= 1'b0;
               dbg_wr1_rd0    <= 1'b0;
            end
            ST_READ: begin
               if (rd_done) begin
                  state          <= ST_DONE;
                  dbg_reg_access <= 1'b0;
                  tmo_cnt        <= '0;
               end else if (tmo_hit) begin
                  state          <= ST_IDLE;
                  busy           <= 1'b0;
                  dbg_reg_access <= 1'b0;
                  tmo_cnt        <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               if (cmd_q.postinc)
                  cmd_q.regno <= regno_inc;
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_abs_cmd_seq.sv
// Directed bench for abs_cmd_seq: a vector table of complete commands plus
// hand-written sequences for error lockout and reset during a core read.
module tb_abs_cmd_seq;

   logic        sys_clk;
   logic        sys_rst;
   logic        cmd_update;
   logic [31:0] command;
   logic        autoexec_trig;
   logic [31:0] data0;
   logic [2:0]  cmderr_w1c;
   logic        hart_halted;
   logic        busy;
   logic [2:0]  cmderr;
   logic        data0_we;
   logic [31:0] data0_wdata;
   logic        regno_upd;
   logic [15:0] regno_new;
   logic        dbg_reg_access;
   logic        dbg_wr1_rd0;
   logic [15:0] dbg_regno;
   logic [31:0] dbg_write_data;
   logic        dbg_read_data_valid;
   logic [31:0] dbg_read_data;

   int n_tests = 0;
   int n_fail  = 0;

   abs_cmd_seq #(.REGNO_W(16), .TMO_CYCLES(64)) dut (
      .sys_clk             (sys_clk),
      .sys_rst             (sys_rst),
      .cmd_update          (cmd_update),
      .command             (command),
      .autoexec_trig       (autoexec_trig),
      .data0               (data0),
      .cmderr_w1c          (cmderr_w1c),
      .hart_halted         (hart_halted),
      .busy                (busy),
      .cmderr              (cmderr),
      .data0_we            (data0_we),
      .data0_wdata         (data0_wdata),
      .regno_upd           (regno_upd),
      .regno_new           (regno_new),
      .dbg_reg_access      (dbg_reg_access),
      .dbg_wr1_rd0         (dbg_wr1_rd0),
      .dbg_regno           (dbg_regno),
      .dbg_write_data      (dbg_write_data),
      .dbg_read_data_valid (dbg_read_data_valid),
      .dbg_read_data       (dbg_read_data)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [31:0] cmd;
      logic        use_auto;
      logic        halted;
      logic [31:0] d0;
      logic [31:0] rdata;
      int          lat;        // idle read cycles before valid; -1 = never
      int          poke;       // busy cycle index of a stray cmd_update; -1 = none
      logic [2:0]  exp_err;
      int          exp_acc;
      logic        exp_wr;
      logic [15:0] exp_regno;
      int          exp_we;
      int          exp_busy;
      int          exp_upd;
      logic [15:0] exp_updv;
   } vec_t;

   vec_t vecs [0:17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          acc, busy_n, we_n, upd_n, rd_n;
      logic        wr;
      logic [15:0] rg, updv;
      logic [31:0] wd, rdv;
      bit          done;
      acc = 0; busy_n = 0; we_n = 0; upd_n = 0; rd_n = 0;
      wr = 1'b0; rg = '0; updv = '0; wd = '0; rdv = '0; done = 1'b0;

      @(negedge sys_clk);
      cmderr_w1c = 3'b111;
      @(negedge sys_clk);
      cmderr_w1c  = 3'b000;
      hart_halted = v.halted;
      data0       = v.d0;
      if (v.use_auto) autoexec_trig = 1'b1;
      else begin
         cmd_update = 1'b1;
         command    = v.cmd;
      end
      @(negedge sys_clk);
      cmd_update    = 1'b0;
      autoexec_trig = 1'b0;

      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         #1;
         if (!busy) done = 1'b1;
         else begin
            busy_n++;
            dbg_read_data_valid = 1'b0;
            if (cyc == v.poke) begin
               cmd_update = 1'b1;
               command    = 32'h00231000;
            end else cmd_update = 1'b0;
            if (dbg_reg_access) begin
               acc++;
               wr = dbg_wr1_rd0;
               rg = dbg_regno;
               wd = dbg_write_data;
               if (!dbg_wr1_rd0) begin
                  rd_n++;
                  if (rd_n == v.lat + 1) begin
                     dbg_read_data_valid = 1'b1;
                     dbg_read_data       = v.rdata;
                  end
               end
            end
            #1;
            if (data0_we) begin
               we_n++;
               rdv = data0_wdata;
            end
            if (regno_upd) begin
               upd_n++;
               updv = regno_new;
            end
            @(negedge sys_clk);
         end
      end
      cmd_update          = 1'b0;
      dbg_read_data_valid = 1'b0;

      if (!done) check($sformatf("v%0d_finish", idx), 32'd0, 32'd1);
      check($sformatf("v%0d_cmderr", idx), 32'(cmderr), 32'(v.exp_err));
      check($sformatf("v%0d_busy_cycles", idx), busy_n, v.exp_busy);
      check($sformatf("v%0d_access_cycles", idx), acc, v.exp_acc);
      check($sformatf("v%0d_data0_we", idx), we_n, v.exp_we);
      check($sformatf("v%0d_regno_upd", idx), upd_n, v.exp_upd);
      if (v.exp_acc > 0) begin
         check($sformatf("v%0d_regno", idx), 32'(rg), 32'(v.exp_regno));
         check($sformatf("v%0d_wr1_rd0", idx), 32'(wr), 32'(v.exp_wr));
      end
      if (v.exp_wr) check($sformatf("v%0d_write_data", idx), wd, v.d0);
      if (v.exp_we > 0) check($sformatf("v%0d_read_data", idx), rdv, v.rdata);
      if (v.exp_upd > 0) check($sformatf("v%0d_regno_new", idx), 32'(updv), 32'(v.exp_updv));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //             cmd           auto  h     d0            rdata         lat poke err  acc wr regno    we busy upd updv
      vecs[0]  = '{32'h00221001, 1'b0, 1'b1, 32'h0,        32'hDEADBEEF,  3, -1, 3'd0,  4, 0, 16'h1001, 1,  6, 0, 16'h0};
      vecs[1]  = '{32'h00231002, 1'b0, 1'b1, 32'h12345678, 32'h0,         0, -1, 3'd0,  1, 1, 16'h1002, 0,  3, 0, 16'h0};
      vecs[2]  = '{32'h002A1005, 1'b0, 1'b1, 32'h0,        32'h11111111,  0, -1, 3'd0,  1, 0, 16'h1005, 1,  3, 1, 16'h1006};
      vecs[3]  = '{32'h0,        1'b1, 1'b1, 32'h0,        32'h22222222,  1, -1, 3'd0,  2, 0, 16'h1006, 1,  4, 1, 16'h1007};
      vecs[4]  = '{32'h0,        1'b1, 1'b1, 32'h0,        32'h33333333,  0, -1, 3'd0,  1, 0, 16'h1007, 1,  3, 1, 16'h1008};
      vecs[5]  = '{32'h00221001, 1'b0, 1'b0, 32'h0,        32'h0,         0, -1, 3'd4,  0, 0, 16'h0,    0,  1, 0, 16'h0};
      vecs[6]  = '{32'h00321000, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd2,  0, 0, 16'h0,    0,  1, 0, 16'h0};
      vecs[7]  = '{32'h00222000, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd3,  0, 0, 16'h0,    0,  1, 0, 16'h0};
      vecs[8]  = '{32'h01221000, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd2,  0, 0, 16'h0,    0,  1, 0, 16'h0};
      vecs[9]  = '{32'h00261000, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd2,  0, 0, 16'h0,    0,  1, 0, 16'h0};
      vecs[10] = '{32'h0022101F, 1'b0, 1'b1, 32'h0,        32'hCAFEF00D,  0, -1, 3'd0,  1, 0, 16'h101F, 1,  3, 0, 16'h0};
      vecs[11] = '{32'h00221020, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd3,  0, 0, 16'h0,    0,  1, 0, 16'h0};
      vecs[12] = '{32'h00220000, 1'b0, 1'b1, 32'h0,        32'h00000042,  2, -1, 3'd0,  3, 0, 16'h0000, 1,  5, 0, 16'h0};
      vecs[13] = '{32'h0028FFFF, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd0,  0, 0, 16'h0,    0,  2, 1, 16'h0000};
      vecs[14] = '{32'h00201234, 1'b0, 1'b1, 32'h0,        32'h0,         0, -1, 3'd0,  0, 0, 16'h0,    0,  2, 0, 16'h0};
      vecs[15] = '{32'h00221010, 1'b0, 1'b1, 32'h0,        32'hA5A50F0F, 10,  3, 3'd1, 11, 0, 16'h1010, 1, 13, 0, 16'h0};
      vecs[16] = '{32'h00220300, 1'b0, 1'b1, 32'h0,        32'h0,        -1, -1, 3'd3, 64, 0, 16'h0300, 0, 65, 0, 16'h0};
      vecs[17] = '{32'h00230FFF, 1'b0, 1'b1, 32'h0BADF00D, 32'h0,         0, -1, 3'd0,  1, 1, 16'h0FFF, 0,  3, 0, 16'h0};

      sys_rst = 1'b1;
      cmd_update = 1'b0; command = '0; autoexec_trig = 1'b0; data0 = '0;
      cmderr_w1c = '0; hart_halted = 1'b0; dbg_read_data_valid = 1'b0; dbg_read_data = '0;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmderr", 32'(cmderr), 32'd0);
      check("rst_access", {dbg_reg_access, dbg_wr1_rd0, regno_upd, data0_we}, 32'd0);
      check("rst_regno", {dbg_regno, regno_new}, 32'd0);
      check("rst_write_data", dbg_write_data, 32'd0);

      // autoexec with no command ever accepted must not start anything
      @(negedge sys_clk);
      hart_halted = 1'b1;
      autoexec_trig = 1'b1;
      @(negedge sys_clk);
      autoexec_trig = 1'b0;
      #1;
      check("auto_before_cmd_busy", 32'(busy), 32'd0);
      check("auto_before_cmd_err", 32'(cmderr), 32'd0);

      for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

      // error lockout: triggers ignored until cmderr cleared
      run_vec(100, vecs[5]);
      @(negedge sys_clk);
      hart_halted = 1'b1;
      cmd_update = 1'b1;
      command = 32'h00231002;
      @(negedge sys_clk);
      cmd_update = 1'b0;
      #1;
      check("lock_cmd_busy", 32'(busy), 32'd0);
      check("lock_cmd_err", 32'(cmderr), 32'd4);
      @(negedge sys_clk);
      autoexec_trig = 1'b1;
      @(negedge sys_clk);
      autoexec_trig = 1'b0;
      #1;
      check("lock_auto_busy", 32'(busy), 32'd0);
      @(negedge sys_clk);
      cmderr_w1c = 3'b011;
      @(negedge sys_clk);
      cmderr_w1c = 3'b000;
      #1;
      check("lock_partial_clear", 32'(cmderr), 32'd4);
      @(negedge sys_clk);
      cmderr_w1c = 3'b111;
      @(negedge sys_clk);
      cmderr_w1c = 3'b000;
      #1;
      check("lock_full_clear", 32'(cmderr), 32'd0);
      run_vec(101, vecs[1]);

      // reset while a read is outstanding
      @(negedge sys_clk);
      hart_halted = 1'b1;
      command = 32'h00220300;
      cmd_update = 1'b1;
      @(negedge sys_clk);
      cmd_update = 1'b0;
      repeat (3) @(negedge sys_clk);
      #1;
      check("mid_read_access", {dbg_reg_access, dbg_wr1_rd0}, 32'h2);
      check("mid_read_regno", 32'(dbg_regno), 32'h0300);
      dbg_read_data_valid = 1'b1;
      dbg_read_data = 32'h77;
      #1;
      check("mid_read_we", 32'(data0_we), 32'd1);
      sys_rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(busy), 32'd0);
      check("async_rst_strobes", {dbg_reg_access, dbg_wr1_rd0, data0_we, regno_upd}, 32'd0);
      check("async_rst_regno", 32'(dbg_regno), 32'd0);
      dbg_read_data_valid = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      autoexec_trig = 1'b1;
      @(negedge sys_clk);
      autoexec_trig = 1'b0;
      #1;
      check("post_rst_auto_busy", 32'(busy), 32'd0);
      run_vec(102, vecs[17]);
      run_vec(103, vecs[0]);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
